// File: rtl/ultrasonic_multi_ranger.sv
// Round-robin ultrasonic ranger: triggers one sensor at a time, times its echo in
// microsecond ticks and converts to centimetres by counting US_PER_CM-tick slices.
module ultrasonic_multi_ranger #(
  parameter int unsigned CLK_HZ     = 100_000_000,
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned DIST_W     = 10,
  parameter int unsigned TRIG_US    = 10,
  parameter int unsigned US_PER_CM  = 58,
  parameter int unsigned TIMEOUT_US = 30000,
  parameter int unsigned GAP_US     = 60000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [NUM_CH-1:0]          echo,
  output logic [NUM_CH-1:0]          trig,
  output logic [NUM_CH*DIST_W-1:0]   distance,
  output logic [NUM_CH-1:0]          valid,
  output logic [NUM_CH-1:0]          err,
  output logic                       busy
);

  localparam int unsigned DIV    = CLK_HZ / 1_000_000;
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SUB_W  = (US_PER_CM > 1) ? $clog2(US_PER_CM) : 1;
  localparam int unsigned MAX_TG = (TIMEOUT_US > GAP_US) ? TIMEOUT_US : GAP_US;
  localparam int unsigned MAX_US = (MAX_TG > TRIG_US) ? MAX_TG : TRIG_US;
  localparam int unsigned US_W   = $clog2(MAX_US + 1);

  localparam logic [DIV_W-1:0] DIV_LAST     = DIV_W'(DIV - 1);
  localparam logic [US_W-1:0]  TRIG_LAST    = US_W'(TRIG_US - 1);
  localparam logic [US_W-1:0]  TIMEOUT_LAST = US_W'(TIMEOUT_US - 1);
  localparam logic [US_W-1:0]  GAP_LAST     = US_W'(GAP_US - 1);
  localparam logic [SUB_W-1:0] SUB_LAST     = SUB_W'(US_PER_CM - 1);
  localparam logic [CH_W-1:0]  CH_LAST      = CH_W'(NUM_CH - 1);

  typedef enum logic [2:0] {
    StIdle,
    StTrig,
    StWaitRise,
    StMeasure,
    StGap
  } state_e;

  state_e              state_q;
  logic [CH_W-1:0]     ch_q;
  logic [DIV_W-1:0]    div_q;
  logic [US_W-1:0]     us_q;
  logic [SUB_W-1:0]    sub_q;
  logic [DIST_W-1:0]   cm_q;
  logic [NUM_CH-1:0]   echo_s1, echo_s2, echo_s3;

  logic                tick;
  logic                echo_cur, echo_prev, rise, fall;
  logic                sub_wrap;
  logic [SUB_W-1:0]    sub_next;
  logic [DIST_W-1:0]   cm_next;

  always_comb begin
    tick      = (div_q == DIV_LAST);
    echo_cur  = echo_s2[ch_q];
    echo_prev = echo_s3[ch_q];
    rise      = echo_cur & ~echo_prev;
    fall      = ~echo_cur & echo_prev;
    sub_wrap  = tick && (sub_q == SUB_LAST);
    sub_next  = sub_q;
    if (tick) sub_next = sub_wrap ? '0 : sub_q + 1'b1;
    // Include this cycle's tick so an echo ending on a tick boundary counts fully.
    cm_next   = (sub_wrap && !(&cm_q)) ? cm_q + 1'b1 : cm_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      ch_q     <= '0;
      div_q    <= '0;
      us_q     <= '0;
      sub_q    <= '0;
      cm_q     <= '0;
      echo_s1  <= '0;
      echo_s2  <= '0;
      echo_s3  <= '0;
      trig     <= '0;
      distance <= '0;
      valid    <= '0;
      err      <= '0;
      busy     <= 1'b0;
    end else begin
      echo_s1 <= echo;
      echo_s2 <= echo_s1;
      echo_s3 <= echo_s2;
      valid   <= '0;
      div_q   <= tick ? '0 : div_q + 1'b1;
      if (tick) us_q <= us_q + 1'b1;

      unique case (state_q)
        StIdle: begin
          if (enable) begin
            state_q    <= StTrig;
            trig[ch_q] <= 1'b1;
            busy       <= 1'b1;
            div_q      <= '0;
            us_q       <= '0;
          end
        end
        StTrig: begin
          if (tick && us_q == TRIG_LAST) begin
            state_q <= StWaitRise;
            trig    <= '0;
            div_q   <= '0;
            us_q    <= '0;
          end
        end
        StWaitRise: begin
          if (rise) begin
            state_q <= StMeasure;
            div_q   <= '0;
            us_q    <= '0;
            sub_q   <= '0;
            cm_q    <= '0;
          end else if (tick && us_q == TIMEOUT_LAST) begin
            state_q   <= StGap;
            err[ch_q] <= 1'b1;
            div_q     <= '0;
            us_q      <= '0;
          end
        end
        StMeasure: begin
          if (fall) begin
            for (int k = 0; k < NUM_CH; k++) begin
              if (ch_q == CH_W'(k)) distance[k*DIST_W +: DIST_W] <= cm_next;
            end
            valid[ch_q] <= 1'b1;
            err[ch_q]   <= 1'b0;
            state_q     <= StGap;
            div_q       <= '0;
            us_q        <= '0;
          end else if (tick && us_q == TIMEOUT_LAST) begin
            state_q   <= StGap;
            err[ch_q] <= 1'b1;
            div_q     <= '0;
            us_q      <= '0;
          end else begin
            sub_q <= sub_next;
            cm_q  <= cm_next;
          end
        end
        StGap: begin
          if (tick && us_q == GAP_LAST) begin
            state_q <= StIdle;
            ch_q    <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
            busy    <= 1'b0;
            div_q   <= '0;
            us_q    <= '0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ultrasonic_multi_ranger.sv
// Directed bench for ultrasonic_multi_ranger, scaled to a 4 MHz tick divider and short
// timeout/gap so the run stays short; a second instance covers cm-counter saturation.
module tb_ultrasonic_multi_ranger;

  localparam int unsigned CLK_HZ  = 4_000_000;  // 4 clocks per microsecond
  localparam int unsigned CPU     = 4;
  localparam int unsigned TMO_US  = 2000;
  localparam int unsigned GAP_US  = 100;

  logic        clk = 1'b0;
  logic        reset, enable;
  logic [1:0]  echo, trig, valid, err;
  logic [19:0] distance;
  logic        busy;

  logic        reset2, enable2;
  logic [1:0]  echo2, trig2, valid2, err2;
  logic [7:0]  distance2;
  logic        busy2;

  int checks = 0;
  int failures = 0;
  int vcnt0 = 0, vcnt1 = 0, vcnt2 = 0, overlap = 0;

  always #5 clk = ~clk;

  ultrasonic_multi_ranger #(
    .CLK_HZ(CLK_HZ), .NUM_CH(2), .DIST_W(10), .TRIG_US(10), .US_PER_CM(58),
    .TIMEOUT_US(TMO_US), .GAP_US(GAP_US)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .echo(echo), .trig(trig),
    .distance(distance), .valid(valid), .err(err), .busy(busy)
  );

  ultrasonic_multi_ranger #(
    .CLK_HZ(CLK_HZ), .NUM_CH(2), .DIST_W(4), .TRIG_US(10), .US_PER_CM(58),
    .TIMEOUT_US(TMO_US), .GAP_US(GAP_US)
  ) dut_sat (
    .clk(clk), .reset(reset2), .enable(enable2), .echo(echo2), .trig(trig2),
    .distance(distance2), .valid(valid2), .err(err2), .busy(busy2)
  );

  always @(negedge clk) begin
    if (valid[0]) vcnt0 <= vcnt0 + 1;
    if (valid[1]) vcnt1 <= vcnt1 + 1;
    if (valid2[0]) vcnt2 <= vcnt2 + 1;
    if (&trig) overlap <= overlap + 1;
  end

  // Wait for the next trigger, measure its width, then drive an echo of us microseconds.
  task automatic run_echo(input int ch, input int us, input bit noise, input bit drop_en,
                          output int trig_ch, output int trig_len);
    trig_ch = -1;
    trig_len = 0;
    for (int i = 0; i < 20000 && trig == 2'b00; i++) @(negedge clk);
    if (trig == 2'b00) return;
    trig_ch = trig[1] ? 1 : 0;
    if (drop_en) enable = 1'b0;
    for (int i = 0; i < 2000 && trig != 2'b00; i++) begin
      trig_len++;
      @(negedge clk);
    end
    repeat (20) @(negedge clk);
    if (us > 0) begin
      echo[ch] = 1'b1;
      if (noise) echo[1-ch] = 1'b1;
      repeat (us * CPU) @(negedge clk);
      echo = 2'b00;
    end
  endtask

  task automatic wait_idle(output bit ok);
    for (int i = 0; i < 20000 && busy !== 1'b0; i++) @(negedge clk);
    ok = (busy === 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; echo = 2'b00;
    reset2 = 1'b1; enable2 = 1'b0; echo2 = 2'b00;
    repeat (3) @(negedge clk);
    checks++;
    if (trig !== 2'b00 || valid !== 2'b00 || err !== 2'b00 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: trig=%b valid=%b err=%b busy=%b required all 0",
               trig, valid, err, busy);
    end
    checks++;
    if (distance !== 20'd0) begin
      failures++;
      $display("FAIL reset_distance: got %0h required 0", distance);
    end
    reset = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || trig !== 2'b00) begin
      failures++;
      $display("FAIL idle_disabled: busy=%b trig=%b required 0/00", busy, trig);
    end
  endtask

  task automatic test_single;
    int tc, tl, v0;
    bit ok;
    v0 = vcnt0;
    enable = 1'b1;
    run_echo(0, 584, 1'b0, 1'b0, tc, tl);
    wait_idle(ok);
    checks++;
    if (tc !== 0) begin failures++; $display("FAIL single_ch: got %0d required 0", tc); end
    checks++;
    if (tl !== 40) begin failures++; $display("FAIL trig_width: got %0d required 40", tl); end
    checks++;
    if (!ok) begin failures++; $display("FAIL single_idle: busy=%b required 0", busy); end
    checks++;
    if (distance[9:0] !== 10'd10) begin
      failures++; $display("FAIL single_dist: got %0d required 10", distance[9:0]);
    end
    checks++;
    if (vcnt0 - v0 !== 1) begin
      failures++; $display("FAIL single_valid: got %0d pulses required 1", vcnt0 - v0);
    end
    checks++;
    if (err[0] !== 1'b0) begin failures++; $display("FAIL single_err: got %b required 0", err[0]); end
  endtask

  task automatic test_round_robin;
    int tc, tl, v1, ov;
    bit ok;
    ov = overlap;
    run_echo(1, 300, 1'b0, 1'b0, tc, tl);
    wait_idle(ok);
    checks++;
    if (tc !== 1 || distance[19:10] !== 10'd5) begin
      failures++; $display("FAIL rr_ch1a: ch=%0d dist=%0d required 1/5", tc, distance[19:10]);
    end
    v1 = vcnt1;
    run_echo(0, 150, 1'b1, 1'b0, tc, tl);
    wait_idle(ok);
    checks++;
    if (tc !== 0 || distance[9:0] !== 10'd2) begin
      failures++; $display("FAIL rr_ch0: ch=%0d dist=%0d required 0/2", tc, distance[9:0]);
    end
    checks++;
    if (vcnt1 !== v1 || distance[19:10] !== 10'd5) begin
      failures++;
      $display("FAIL rr_noise: valid1 pulses=%0d dist1=%0d required 0/5", vcnt1 - v1,
               distance[19:10]);
    end
    run_echo(1, 1160, 1'b0, 1'b0, tc, tl);
    wait_idle(ok);
    checks++;
    if (tc !== 1 || distance[19:10] !== 10'd20) begin
      failures++; $display("FAIL rr_ch1b: ch=%0d dist=%0d required 1/20", tc, distance[19:10]);
    end
    checks++;
    if (overlap !== ov || err !== 2'b00) begin
      failures++; $display("FAIL rr_overlap: overlaps=%0d err=%b required 0/00", overlap - ov, err);
    end
  endtask

  task automatic test_pre_high;
    bit ok;
    for (int i = 0; i < 20000 && trig == 2'b00; i++) @(negedge clk);
    checks++;
    if (trig !== 2'b01) begin failures++; $display("FAIL pre_trig: got %b required 01", trig); end
    echo[0] = 1'b1;
    for (int i = 0; i < 2000 && trig != 2'b00; i++) @(negedge clk);
    repeat (100 * CPU) @(negedge clk);
    echo[0] = 1'b0;
    repeat (20 * CPU) @(negedge clk);
    echo[0] = 1'b1;
    repeat (300 * CPU) @(negedge clk);
    echo[0] = 1'b0;
    wait_idle(ok);
    checks++;
    if (distance[9:0] !== 10'd5) begin
      failures++; $display("FAIL pre_high_dist: got %0d required 5", distance[9:0]);
    end
  endtask

  task automatic test_timeout;
    int tc, tl, v0, v1;
    bit ok;
    v1 = vcnt1;
    for (int i = 0; i < 20000 && trig == 2'b00; i++) @(negedge clk);
    checks++;
    if (trig !== 2'b10) begin failures++; $display("FAIL tmo_trig: got %b required 10", trig); end
    for (int i = 0; i < 2000 && trig != 2'b00; i++) @(negedge clk);
    repeat (TMO_US * CPU - 100) @(negedge clk);
    checks++;
    if (err[1] !== 1'b0) begin failures++; $display("FAIL tmo_early: err1=%b required 0", err[1]); end
    repeat (200) @(negedge clk);
    checks++;
    if (err[1] !== 1'b1) begin failures++; $display("FAIL tmo_err: err1=%b required 1", err[1]); end
    wait_idle(ok);
    checks++;
    if (distance[19:10] !== 10'd20 || vcnt1 !== v1) begin
      failures++;
      $display("FAIL tmo_keep: dist1=%0d valid1 pulses=%0d required 20/0", distance[19:10],
               vcnt1 - v1);
    end
    v0 = vcnt0;
    run_echo(0, 2040, 1'b0, 1'b0, tc, tl);
    wait_idle(ok);
    checks++;
    if (tc !== 0) begin failures++; $display("FAIL tmo_wrap: ch=%0d required 0", tc); end
    checks++;
    if (err !== 2'b11 || distance[9:0] !== 10'd5 || vcnt0 !== v0) begin
      failures++;
      $display("FAIL meas_tmo: err=%b dist0=%0d valid0 pulses=%0d required 11/5/0", err,
               distance[9:0], vcnt0 - v0);
    end
  endtask

  task automatic test_reset_mid;
    int tc, tl, v1;
    bit ok;
    v1 = vcnt1;
    for (int i = 0; i < 20000 && trig == 2'b00; i++) @(negedge clk);
    for (int i = 0; i < 2000 && trig != 2'b00; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    echo[1] = 1'b1;
    repeat (200 * CPU) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (trig !== 2'b00 || valid !== 2'b00 || err !== 2'b00 || busy !== 1'b0
        || distance !== 20'd0) begin
      failures++;
      $display("FAIL mid_reset: trig=%b valid=%b err=%b busy=%b dist=%0h required all 0",
               trig, valid, err, busy, distance);
    end
    reset = 1'b0;
    echo = 2'b00;
    run_echo(0, 150, 1'b0, 1'b0, tc, tl);
    wait_idle(ok);
    checks++;
    if (tc !== 0 || distance[9:0] !== 10'd2 || vcnt1 !== v1) begin
      failures++;
      $display("FAIL mid_restart: ch=%0d dist0=%0d valid1 pulses=%0d required 0/2/0", tc,
               distance[9:0], vcnt1 - v1);
    end
  endtask

  task automatic test_enable_drop;
    int tc, tl, v1, act;
    bit ok;
    v1 = vcnt1;
    run_echo(1, 300, 1'b0, 1'b1, tc, tl);
    wait_idle(ok);
    checks++;
    if (tc !== 1 || distance[19:10] !== 10'd5 || vcnt1 - v1 !== 1) begin
      failures++;
      $display("FAIL en_drop_meas: ch=%0d dist1=%0d valid1 pulses=%0d required 1/5/1", tc,
               distance[19:10], vcnt1 - v1);
    end
    act = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (trig != 2'b00 || busy) act++;
    end
    checks++;
    if (act !== 0) begin
      failures++; $display("FAIL en_drop_hold: active cycles=%0d required 0", act);
    end
  endtask

  task automatic test_saturation;
    int v2;
    v2 = vcnt2;
    reset2 = 1'b0;
    enable2 = 1'b1;
    for (int i = 0; i < 2000 && trig2 == 2'b00; i++) @(negedge clk);
    enable2 = 1'b0;
    for (int i = 0; i < 2000 && trig2 != 2'b00; i++) @(negedge clk);
    repeat (20) @(negedge clk);
    echo2[0] = 1'b1;
    repeat (1200 * CPU) @(negedge clk);
    echo2[0] = 1'b0;
    for (int i = 0; i < 20000 && busy2 !== 1'b0; i++) @(negedge clk);
    checks++;
    if (distance2[3:0] !== 4'd15) begin
      failures++; $display("FAIL sat_dist: got %0d required 15", distance2[3:0]);
    end
    checks++;
    if (vcnt2 - v2 !== 1 || err2[0] !== 1'b0) begin
      failures++;
      $display("FAIL sat_valid: pulses=%0d err=%b required 1/0", vcnt2 - v2, err2[0]);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_pre_high();
    test_timeout();
    test_reset_mid();
    test_enable_drop();
    test_saturation();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
